// File: rtl/queue_uart_tx.sv
// queue_uart_tx: pops bytes from the shared 8-bit queue via request/grant and sends them as UART frames
// Ports:
//   Clk_i      clock, rising edge
//   Rst_i      asynchronous reset, active-low
//   tx_en_i    permits starting a new frame (sampled in IDLE)
//   q_empty_i  queue empty flag
//   q_data_i   queue read data, valid in the pop cycle
//   q_gnt_i    arbiter grant for queue access
//   q_req_o    queue access request while a pop is pending
//   q_en_o     queue enable (q_req_o & q_gnt_i), one cycle per byte
//   q_rw_o     queue read/write select, always read (0)
//   tx_o       registered serial line, idles high
//   busy_o     high outside IDLE
//   done_o     pulse in the last cycle of the stop bit
// Optional feature: define QUEUE_UART_TX_PARITY_EN for an even parity bit between data and stop.
module queue_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              Clk_i,
  input  logic              Rst_i,
  input  logic              tx_en_i,
  input  logic              q_empty_i,
  input  logic [DATA_W-1:0] q_data_i,
  input  logic              q_gnt_i,
  output logic              q_req_o,
  output logic              q_en_o,
  output logic              q_rw_o,
  output logic              tx_o,
  output logic              busy_o,
  output logic              done_o
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] BIT_LAST = 3'(DATA_W - 1);
`ifdef QUEUE_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, POP, START, DATA, PARITY, STOP} state_e;
`else
  typedef enum logic [2:0] {IDLE, POP, START, DATA, STOP} state_e;
`endif
  state_e state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic tx_q, tx_d;
  logic bit_end, line;
  assign bit_end = baud_q == BAUD_LAST;
  assign line = state_q != IDLE && state_q != POP;
`ifdef QUEUE_UART_TX_PARITY_EN
  logic par_q;
  // parity is taken from the popped byte since the shift register is consumed during DATA
  always_ff @(posedge Clk_i or negedge Rst_i)
    if (!Rst_i) par_q <= 1'b0;
    else if (q_en_o) par_q <= ^q_data_i;
`endif
  always_ff @(posedge Clk_i or negedge Rst_i)
    if (!Rst_i) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
    end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (tx_en_i && !q_empty_i) state_d = POP;
      POP:    state_d = q_empty_i ? IDLE : q_gnt_i ? START : POP;
      START:  if (bit_end) state_d = DATA;
`ifdef QUEUE_UART_TX_PARITY_EN
      DATA:   if (bit_end && bit_q == BIT_LAST) state_d = PARITY;
      PARITY: if (bit_end) state_d = STOP;
`else
      DATA:   if (bit_end && bit_q == BIT_LAST) state_d = STOP;
`endif
      STOP:   if (bit_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // tx is computed from the next state so the registered line lines up with the state
  always_comb begin
    baud_d  = (line && !bit_end) ? baud_q + 1'b1 : '0;
    bit_d   = state_q != DATA ? 3'd0 : bit_end ? bit_q + 1'b1 : bit_q;
    shift_d = q_en_o ? q_data_i : (state_q == DATA && bit_end) ? shift_q >> 1 : shift_q;
`ifdef QUEUE_UART_TX_PARITY_EN
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : state_d == PARITY ? par_q : 1'b1;
`else
    tx_d = state_d == START ? 1'b0 : state_d == DATA ? shift_d[0] : 1'b1;
`endif
  end
  always_comb begin
    busy_o  = state_q != IDLE;
    q_req_o = state_q == POP && !q_empty_i;
    q_en_o  = q_req_o && q_gnt_i;
    q_rw_o  = 1'b0;
    done_o  = state_q == STOP && bit_end;
    tx_o    = tx_q;
  end
endmodule

// File: tb/tb_queue_uart_tx.sv
// tb_queue_uart_tx: directed vector bench for queue_uart_tx at CLKS_PER_BIT=4
module tb_queue_uart_tx;
  localparam int CPB = 4;
`ifdef QUEUE_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  typedef struct {
    logic [7:0] d;
    logic [7:0] seq;
    logic       par;
    int         stall;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0, tx_en = 1'b0, gnt = 1'b0;
  logic q_empty, q_req, q_en, q_rw, tx, busy, done;
  logic [7:0] q_data;
  logic [7:0] mem [0:7];
  int rd = 0, wr = 0, pops = 0, dones = 0;
  int errs = 0, checks = 0;
  always #5 clk = ~clk;
  assign q_empty = rd == wr;
  assign q_data = mem[rd[2:0]];
  always @(posedge clk) begin
    if (q_en && rd != wr) rd <= rd + 1;
    if (q_en) pops <= pops + 1;
    if (done) dones <= dones + 1;
  end
  queue_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .Clk_i(clk), .Rst_i(rst_n), .tx_en_i(tx_en), .q_empty_i(q_empty), .q_data_i(q_data),
    .q_gnt_i(gnt), .q_req_o(q_req), .q_en_o(q_en), .q_rw_o(q_rw), .tx_o(tx), .busy_o(busy),
    .done_o(done)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic push(input logic [7:0] d);
    mem[wr[2:0]] = d;
    wr++;
  endtask
  // called at the negedge of line cycle 0; returns at the negedge of the following IDLE cycle
  task automatic expect_frame(input logic [7:0] seq, input logic par, input string nm);
    logic e;
    for (int c = 0; c < NB * CPB; c++) begin
      int b = c / CPB;
      e = (b == 0) ? 1'b0 : (b <= 8) ? seq[8-b] : (b == 9 && NB == 11) ? par : 1'b1;
      chk({nm, " tx"}, tx, e);
      chk({nm, " done"}, done, c == NB * CPB - 1);
      chk({nm, " busy"}, busy, 1);
      @(negedge clk);
    end
    chk({nm, " idle after"}, busy, 0);
  endtask
  initial begin
    vec_t tbl [4];
    int p0, d0;
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    tbl[0] = '{8'hA5, 8'b10100101, 1'b0, 0};
    tbl[1] = '{8'h4D, 8'b10110010, 1'b0, 5};
    tbl[2] = '{8'h07, 8'b11100000, 1'b1, 2};
    tbl[3] = '{8'h03, 8'b11000000, 1'b0, 0};
    @(negedge clk);
    chk("rst tx", tx, 1);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst req", q_req, 0);
    chk("rst en", q_en, 0);
    chk("rst rw", q_rw, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      p0 = pops;
      d0 = dones;
      gnt = 1'b0;
      tx_en = 1'b1;
      push(8'hFF);
      #1;
      chk("vec idle busy", busy, 0);
      @(negedge clk);
      for (int s = 0; s < tbl[i].stall; s++) begin
        chk("stall req", q_req, 1);
        chk("stall en", q_en, 0);
        chk("stall tx", tx, 1);
        @(negedge clk);
      end
      mem[rd[2:0]] = tbl[i].d;
      gnt = 1'b1;
      #1;
      chk("pop req", q_req, 1);
      chk("pop en", q_en, 1);
      chk("pop rw", q_rw, 0);
      @(negedge clk);
      gnt = 1'b0;
      expect_frame(tbl[i].seq, tbl[i].par, "vec");
      chk("vec pop count", pops - p0, 1);
      chk("vec done count", dones - d0, 1);
    end
    p0 = pops;
    gnt = 1'b1;
    push(8'h01);
    push(8'h80);
    @(negedge clk);
    chk("b2b pop1 en", q_en, 1);
    @(negedge clk);
    expect_frame(8'b10000000, 1'b1, "b2b f1");
    chk("b2b gap req", q_req, 0);
    @(negedge clk);
    chk("b2b pop2 en", q_en, 1);
    @(negedge clk);
    expect_frame(8'b00000001, 1'b1, "b2b f2");
    chk("b2b pop count", pops - p0, 2);
    p0 = pops;
    push(8'h11);
    push(8'h22);
    push(8'h33);
    @(negedge clk);
    chk("drop pop en", q_en, 1);
    @(negedge clk);
    tx_en = 1'b0;
    expect_frame(8'b10001000, 1'b0, "drop f1");
    for (int k = 0; k < 5; k++) begin
      chk("drop no req", q_req, 0);
      chk("drop idle", busy, 0);
      @(negedge clk);
    end
    chk("drop pop count", pops - p0, 1);
    wr = rd;
    tx_en = 1'b1;
    d0 = dones;
    push(8'hA5);
    @(negedge clk);
    chk("rst pop en", q_en, 1);
    @(negedge clk);
    repeat (17) @(negedge clk);
    chk("pre-reset tx", tx, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst tx", tx, 1);
    chk("async rst busy", busy, 0);
    chk("async rst req", q_req, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post rst idle", busy, 0);
      chk("post rst req", q_req, 0);
    end
    chk("aborted no done", dones - d0, 0);
    push(8'h4D);
    @(negedge clk);
    chk("post rst pop en", q_en, 1);
    @(negedge clk);
    expect_frame(8'b10110010, 1'b0, "post rst");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/queue_uart_tx.md
Name: queue_uart_tx

Overview:
Downstream drain stage for the 8-bit queue. Pops one byte at a time while the queue is non-empty and transmission is enabled, then serialises it as a UART frame: start bit, 8 data bits LSB first, optional parity bit, stop bit. Queue access goes through a request/grant handshake so top level can arbitrate the queue's shared read/write control against the upstream writer.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; legal values are 2 or more.
DATA_W, 8, byte width; fixed at 8 to match the queue.

Ports:
Clk_i  input  1  clock, all state updates on rising edge
Rst_i  input  1  asynchronous reset, active-low
tx_en_i  input  1  permits starting a new frame
q_empty_i  input  1  queue empty flag
q_data_i  input  8  queue read data, valid only during the pop cycle
q_gnt_i  input  1  arbiter grant for queue access
q_req_o  output  1  request for queue access (pop pending)
q_en_o  output  1  queue enable, equals q_req_o AND q_gnt_i
q_rw_o  output  1  queue read/write select; constant 0 (read/pop)
tx_o  output  1  serial line, idles high
busy_o  output  1  high in every state except IDLE
done_o  output  1  one-cycle pulse in the last cycle of the stop bit

Behaviour:
- Reset (Rst_i=0, asynchronous, takes effect immediately, mid-frame included):
  - state=IDLE, bit and baud counters=0, shift register=0.
  - tx_o=1; busy_o, done_o, q_req_o, q_en_o and q_rw_o all 0.
  - Any partial frame is abandoned. No pop is issued.
- States are IDLE, POP, START, DATA, [PARITY], STOP.
- IDLE: if tx_en_i=1 and q_empty_i=0, go to POP next cycle. Otherwise stay.
- POP:
  - q_req_o=1.
  - On a cycle with q_gnt_i=1, q_en_o=1 and q_rw_o=0. At that clock edge q_data_i is latched into the shift register (the queue advances its front pointer on the same edge). Next state is START.
  - Without grant, stay in POP holding q_req_o.
  - If q_empty_i=1 while in POP, return to IDLE with no pop.
  - q_en_o is high for exactly one cycle per byte.
- START: tx_o=0 for CLKS_PER_BIT cycles.
- DATA:
  - tx_o=shift[0] for CLKS_PER_BIT cycles per bit; shift right after each bit.
  - Bit counter runs 0..7. After bit 7, go to PARITY if that state is built, otherwise to STOP.
- STOP: tx_o=1 for CLKS_PER_BIT cycles. done_o=1 in the final cycle. Then go to IDLE.
- Frame timing: 1 IDLE + at least 1 POP cycle + 10×CLKS_PER_BIT line cycles (11×CLKS_PER_BIT with parity). Back-to-back bytes have exactly one IDLE cycle between frames.
- Baud counter is $clog2(CLKS_PER_BIT) bits wide. It counts 0..CLKS_PER_BIT-1 and wraps to 0 on every bit boundary.
- tx_en_i and q_empty_i are sampled only in IDLE (q_empty_i also in POP). Deasserting tx_en_i mid-frame lets the current frame finish.
- tx_o is driven from a register, so there is no combinational path from inputs to tx_o.

Optional Feature:
QUEUE_UART_TX_PARITY_EN
- Defined: adds a PARITY state between DATA and STOP. tx_o = XOR of the 8 latched data bits (even parity), held for CLKS_PER_BIT cycles. Frame is 11 bits.
- Undefined: no PARITY state, no parity logic. Frame is 10 bits.

Test Plan:
1. Reset mid-frame: set CLKS_PER_BIT=4, start a frame, pull Rst_i low in DATA bit 3 -> tx_o=1 and busy_o=0 in the same cycle without a clock edge. After release, the block stays IDLE until q_empty_i=0.
2. Single byte: CLKS_PER_BIT=4, q_empty_i=0, q_gnt_i=1, q_data_i=8'hA5 -> q_en_o high exactly 1 cycle with q_rw_o=0. tx_o sequence, 4 cycles per bit: 0, 1,0,1,0,0,1,0,1, 1. done_o pulses once; total 1+1+40 cycles.
3. Grant stall: hold q_gnt_i=0 for 5 cycles in POP -> q_req_o=1 and q_en_o=0 throughout. tx_o stays 1. Raising q_gnt_i gives a single q_en_o pulse and latches the byte present that cycle.
4. Back-to-back: queue holds 8'h01 then 8'h80, tx_en_i=1 -> two frames separated by exactly 1 IDLE cycle, two q_en_o pulses, data LSB first.
5. Enable drop: clear tx_en_i during frame 1 of 3 queued bytes -> frame 1 completes, no further q_req_o, busy_o=0 afterward.
6. Parity (macro defined): q_data_i=8'h07 -> parity bit 1. q_data_i=8'h03 -> parity bit 0. Frame is 44 line cycles at CLKS_PER_BIT=4.
